uart_fifo_periph: RTL and testbench
===================================

Name: uart_fifo_periph

Overview:
Parametrised next-generation memory-mapped UART peripheral for the processor's peripheral bus. It replaces the single-byte data/control register pair with TX and RX FIFOs, a programmable 16x-oversampling baud divisor, configurable frame format, sticky error flags and an interrupt output. Software writes bytes to a data register, which queues them; received bytes queue for later reads.

Parameters:
DATA_W, 8, data bits per frame (5..8)
FIFO_DEPTH, 8, entries per FIFO (power of two, 2..64)
PARITY_EN, 0, 1 = insert/check even parity bit
STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks one
DIV_RESET, 16'd53, reset divisor (100 MHz / (16 x 115200) - 1)

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
entrada_i  in  32  write data from bus
reg_sel_i  in  2  register select: 0 CTRL/STATUS, 1 DATA, 2 DIV, 3 reserved
wr_i  in  1  write strobe, one cycle
rd_i  in  1  read strobe, one cycle (pops RX FIFO when reg_sel_i==1)
rx  in  1  serial input, asynchronous
tx  out  1  serial output
salida_o  out  32  read data, combinational on reg_sel_i
irq_o  out  1  interrupt, level

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low on reset_ni.
- On reset: tx=1, irq_o=0, both FIFOs empty, CTRL=0, sticky flags=0, DIV=DIV_RESET, both FSMs IDLE.
- CTRL write bits: [0] tx_en, [1] rx_en, [2] rx_ie, [3] tx_ie. These bits are stored.
- CTRL write bits [4] tx_flush, [5] rx_flush and [6] err_clr are self-clearing one-cycle actions.
- STATUS read: [3:0] stored CTRL bits, [8] tx_full, [9] tx_empty, [10] rx_full, [11] rx_empty, [12] tx_busy, [13] overrun, [14] frame_err, [15] parity_err.
- STATUS read: [22:16] tx_count, [30:24] rx_count. All other bits read 0.
- DATA write: entrada_i[DATA_W-1:0] is pushed to the TX FIFO. A write while full is dropped; no flag is set.
- DATA read: salida_o = zero-extended RX FIFO head (0 when empty). rd_i pops at the clock edge if not empty.
- DIV register: 16 bits, read/write. Reserved address reads 0; writes to it are ignored.
- Baud tick: one-cycle pulse every DIV+1 clocks. The counter reloads on each tick or on a DIV write. A new DIV is used from the next reload.
- One bit period = 16 ticks.
- TX FSM states: IDLE -> START -> DATA (DATA_W bits, LSB first) -> PARITY (only if PARITY_EN) -> STOP (STOP_BITS periods) -> IDLE.
- TX leaves IDLE when tx_en=1 and the TX FIFO is not empty. It pops the FIFO the same cycle, and the start bit is driven from the next tick.
- tx_busy = state != IDLE.
- Clearing tx_en mid-frame lets the current frame finish; no further pops occur.
- RX input passes through a 2-flop synchronizer.
- RX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- IDLE to START on a falling edge when rx_en=1. In START, the line is re-sampled after 8 ticks: if high, it is a glitch and the FSM returns to IDLE; if low, it proceeds. After that, sampling occurs every 16 ticks (mid-bit).
- STOP sample low sets frame_err. A parity mismatch sets parity_err. The byte is pushed regardless.
- A push while the RX FIFO is full drops the byte and sets overrun.
- Sticky flags clear only on err_clr or reset. If err_clr and a new error occur in the same cycle, the error wins.
- FIFO push and pop in the same cycle: both take effect even when full (TX) or empty-with-push (count unchanged/bypass not required; pop of empty is ignored).
- Flush empties the FIFO in one cycle. It does not abort a frame already in flight.
- irq_o = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy) | overrun | frame_err | parity_err.
- Reset asserted mid-frame: tx goes to 1 immediately; the partial frame is lost.

Decomposition:
- Package uart_pkg holds:
  - register address localparams (ADDR_CTRL=0, ADDR_DATA=1, ADDR_DIV=2);
  - CTRL/STATUS bit-index localparams;
  - enum tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP};
  - enum rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP}.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, din, dout, full, empty, count) is instantiated twice.
- The baud generator and both FSMs stay in the top.

Test Plan:
- Reset, then read each register -> STATUS=0x0000_0A00 (tx_empty, rx_empty), DIV=53, tx=1, irq_o=0.
- DIV=0, CTRL=0x1, write DATA 0xA5 -> tx low for 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high; total 160 clocks; tx_busy then drops.
- Loop tx to rx, CTRL=0x7, write 0x3C, 0xC3 -> rx_count=2, irq_o=1; DATA reads return 0x3C then 0xC3; rx_empty=1 after both reads.
- Write 9 bytes with tx_en=0, FIFO_DEPTH=8 -> tx_count=8, tx_full=1, 9th byte lost; set tx_en -> exactly 8 frames sent.
- Drive 9 frames on rx without reading -> rx_full=1, overrun=1, irq_o=1; CTRL write 0x43 (err_clr) -> overrun=0, the 8 stored bytes are intact.
- Stop bit forced low on 0x55 -> frame_err=1 and byte 0x55 stored. A 4-clock low glitch at DIV=0 -> no byte is stored.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-based UART peripheral.
// - Register addresses of the bus-visible register file.
// - CTRL (write) and STATUS (read) bit positions.
// - Tick-count constants for 16x oversampling.
// - State encodings for the transmit and receive FSMs.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register map (reg_sel_i)
    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    // CTRL write bits. The lower four are stored; the rest are one-cycle actions.
    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_RX_IE    = 2;
    localparam int CTRL_TX_IE    = 3;
    localparam int CTRL_TX_FLUSH = 4;
    localparam int CTRL_RX_FLUSH = 5;
    localparam int CTRL_ERR_CLR  = 6;

    // STATUS read bits
    localparam int STAT_TX_FULL    = 8;
    localparam int STAT_TX_EMPTY   = 9;
    localparam int STAT_RX_FULL    = 10;
    localparam int STAT_RX_EMPTY   = 11;
    localparam int STAT_TX_BUSY    = 12;
    localparam int STAT_OVERRUN    = 13;
    localparam int STAT_FRAME_ERR  = 14;
    localparam int STAT_PARITY_ERR = 15;
    localparam int STAT_TX_CNT_LSB = 16;
    localparam int STAT_RX_CNT_LSB = 24;
    localparam int STAT_CNT_W      = 7;

    // 16 ticks per bit. The receiver re-checks the start bit half a bit in.
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through output.
// - clk_i, reset_ni : clock and asynchronous active-low reset.
// - push, din       : write one entry. A push while full is dropped unless a
//                     pop happens in the same cycle.
// - pop, dout       : dout is the current head. pop removes it. A pop while
//                     empty is ignored.
// - flush           : empties the FIFO in one cycle. It has priority over
//                     push and pop.
// - full, empty, count : occupancy.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // When full, a simultaneous pop frees the slot being written. The head
    // is read combinationally before the write lands, so no bypass is needed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is kept out of the reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_fifo_periph.sv
// -----------------------------------------------------------------------------
// uart_fifo_periph
// Memory-mapped UART with TX/RX FIFOs, 16x oversampling baud generator,
// sticky receive error flags and a level interrupt.
// - clk_i, reset_ni : clock and asynchronous active-low reset.
// - entrada_i       : bus write data.
// - reg_sel_i       : 0 CTRL/STATUS, 1 DATA, 2 DIV, 3 reserved.
// - wr_i, rd_i      : one-cycle strobes. rd_i on DATA pops the RX FIFO.
// - rx, tx          : serial line in (asynchronous) and out.
// - salida_o        : read data, combinational on reg_sel_i.
// - irq_o           : level interrupt.
// -----------------------------------------------------------------------------
module uart_fifo_periph
    import uart_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PARITY_EN  = 0,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] DIV_RESET  = 16'd53
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] entrada_i,
    input  logic [1:0]  reg_sel_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] salida_o,
    output logic        irq_o
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_CNT_W = 3;

    // ---------------- register file ----------------
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic        ctrl_wr, data_wr, div_wr;
    logic        tx_flush, rx_flush, err_clr;

    assign ctrl_wr  = wr_i && (reg_sel_i == ADDR_CTRL);
    assign data_wr  = wr_i && (reg_sel_i == ADDR_DATA);
    assign div_wr   = wr_i && (reg_sel_i == ADDR_DIV);
    assign tx_flush = ctrl_wr && entrada_i[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr && entrada_i[CTRL_RX_FLUSH];
    assign err_clr  = ctrl_wr && entrada_i[CTRL_ERR_CLR];
    assign ctrl_d   = ctrl_wr ? entrada_i[3:0] : ctrl_q;
    assign div_d    = div_wr ? entrada_i[15:0] : div_q;

    logic unused_entrada;
    assign unused_entrada = ^entrada_i[31:16];

    // ---------------- baud generator ----------------
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tick;

    assign tick = (baud_cnt_q == '0);

    always_comb begin
        baud_cnt_d = tick ? div_q : baud_cnt_q - 16'd1;
        // A DIV write restarts the period with the new value straight away.
        if (div_wr) begin
            baud_cnt_d = entrada_i[15:0];
        end
    end

    // ---------------- FIFOs ----------------
    logic [DATA_W-1:0] tx_dout, rx_dout, rx_din;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_pop, rx_push, rx_pop;

    assign rx_pop = rd_i && (reg_sel_i == ADDR_DATA);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (data_wr),
        .pop      (tx_pop),
        .flush    (tx_flush),
        .din      (entrada_i[DATA_W-1:0]),
        .dout     (tx_dout),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (rx_push),
        .pop      (rx_pop),
        .flush    (rx_flush),
        .din      (rx_din),
        .dout     (rx_dout),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    // ---------------- transmitter ----------------
    tx_state_t             tx_state_q, tx_state_d;
    logic [3:0]            tx_tick_q, tx_tick_d;
    logic [BIT_CNT_W-1:0]  tx_bit_q, tx_bit_d;
    logic                  tx_stop_q, tx_stop_d;
    logic [DATA_W-1:0]     tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_line;
    logic                  tx_busy;

    assign tx_busy = (tx_state_q != TX_IDLE);

    // Level the line should carry for the current frame section.
    always_comb begin
        case (tx_state_q)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift_q[0];
            TX_PARITY: tx_line = tx_par_q;
            default:   tx_line = 1'b1;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        if (tx_state_q == TX_IDLE) begin
            tx_d = 1'b1;
            if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_dout;
                tx_par_d   = ^tx_dout;
                tx_tick_d  = '0;
                tx_state_d = TX_START;
            end
        end else if (tick) begin
            // The line changes on ticks only, so each section spans exactly
            // 16 ticks starting at the first tick after entering it.
            tx_d      = tx_line;
            tx_tick_d = tx_tick_q + 4'd1;
            if (tx_tick_q == TICK_LAST) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end
                    TX_DATA: begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + BIT_CNT_W'(1);
                        if (tx_bit_q == BIT_CNT_W'(DATA_W - 1)) begin
                            tx_stop_d  = 1'b0;
                            tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                        end
                    end
                    TX_PARITY: begin
                        tx_stop_d  = 1'b0;
                        tx_state_d = TX_STOP;
                    end
                    TX_STOP: begin
                        tx_stop_d = 1'b1;
                        if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                    default: tx_state_d = TX_IDLE;
                endcase
            end
        end
    end

    assign tx = tx_q;

    // ---------------- receiver ----------------
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [3:0]            rx_tick_q, rx_tick_d;
    logic [BIT_CNT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0]     rx_shift_q, rx_shift_d;
    logic                  rx_fall;
    logic                  frame_set, parity_set, overrun_set;

    assign rx_fall = rx_prev_q && !rx_sync_q;
    assign rx_din  = rx_shift_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (ctrl_q[CTRL_RX_EN] && rx_fall) begin
                    rx_tick_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    // Half a bit in: a line back high means a glitch.
                    if (rx_tick_q == TICK_MID) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == TICK_LAST) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                        rx_bit_d   = rx_bit_q + BIT_CNT_W'(1);
                        if (rx_bit_q == BIT_CNT_W'(DATA_W - 1)) begin
                            rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == TICK_LAST) begin
                        parity_set = (rx_sync_q != ^rx_shift_q);
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == TICK_LAST) begin
                        frame_set  = !rx_sync_q;
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A simultaneous read frees a slot, so that case is not an overrun.
    assign overrun_set = rx_push && rx_full && !rx_pop;

    // ---------------- sticky flags ----------------
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d;

    // A new error in the same cycle as err_clr survives the clear.
    assign overrun_d    = (overrun_q    && !err_clr) || overrun_set;
    assign frame_err_d  = (frame_err_q  && !err_clr) || frame_set;
    assign parity_err_d = (parity_err_q && !err_clr) || parity_set;

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ctrl_q       <= '0;
            div_q        <= DIV_RESET;
            baud_cnt_q   <= DIV_RESET;
            tx_state_q   <= TX_IDLE;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_stop_q    <= 1'b0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_q         <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            div_q        <= div_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_state_q   <= tx_state_d;
            tx_tick_q    <= tx_tick_d;
            tx_bit_q     <= tx_bit_d;
            tx_stop_q    <= tx_stop_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_q         <= tx_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // ---------------- read mux and interrupt ----------------
    always_comb begin
        salida_o = '0;
        case (reg_sel_i)
            ADDR_CTRL: begin
                salida_o[3:0]            = ctrl_q;
                salida_o[STAT_TX_FULL]    = tx_full;
                salida_o[STAT_TX_EMPTY]   = tx_empty;
                salida_o[STAT_RX_FULL]    = rx_full;
                salida_o[STAT_RX_EMPTY]   = rx_empty;
                salida_o[STAT_TX_BUSY]    = tx_busy;
                salida_o[STAT_OVERRUN]    = overrun_q;
                salida_o[STAT_FRAME_ERR]  = frame_err_q;
                salida_o[STAT_PARITY_ERR] = parity_err_q;
                salida_o[STAT_TX_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(tx_count);
                salida_o[STAT_RX_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(rx_count);
            end
            ADDR_DATA: begin
                if (!rx_empty) begin
                    salida_o = 32'(rx_dout);
                end
            end
            ADDR_DIV: salida_o = 32'(div_q);
            default:  salida_o = '0;
        endcase
    end

    assign irq_o = (ctrl_q[CTRL_RX_IE] && !rx_empty)
                 || (ctrl_q[CTRL_TX_IE] && tx_empty && !tx_busy)
                 || overrun_q || frame_err_q || parity_err_q;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph with default parameters
// (DATA_W=8, FIFO_DEPTH=8, no parity, one stop bit, DIV_RESET=53).
module tb_uart_fifo_periph;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [31:0] entrada_i = '0;
    logic [1:0]  reg_sel_i = '0;
    logic        wr_i = 1'b0;
    logic        rd_i = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_w;
    logic        tx;
    logic [31:0] salida_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx_w = loop_en ? tx : rx_drv;

    always #5 clk_i = ~clk_i;

    uart_fifo_periph dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .entrada_i (entrada_i),
        .reg_sel_i (reg_sel_i),
        .wr_i      (wr_i),
        .rd_i      (rd_i),
        .rx        (rx_w),
        .tx        (tx),
        .salida_o  (salida_o),
        .irq_o     (irq_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] sel, input logic [31:0] d);
        reg_sel_i = sel;
        entrada_i = d;
        wr_i      = 1'b1;
        cyc(1);
        wr_i      = 1'b0;
        entrada_i = '0;
    endtask

    task automatic reg_rd(input logic [1:0] sel, output logic [31:0] d);
        reg_sel_i = sel;
        #1;
        d = salida_o;
    endtask

    task automatic data_pop(output logic [31:0] d);
        reg_sel_i = 2'd1;
        rd_i      = 1'b1;
        #1;
        d = salida_o;
        cyc(1);
        rd_i = 1'b0;
    endtask

    // One 8N1 frame on rx at DIV=0 (16 clocks per bit).
    task automatic send_rx(input logic [7:0] data, input logic stop_val);
        rx_drv = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            cyc(16);
        end
        rx_drv = stop_val;
        cyc(16);
        rx_drv = 1'b1;
        cyc(8);
    endtask

    logic [31:0] rd;
    logic [31:0] st;
    logic        samp [161];
    logic [7:0]  a5;
    logic        prev_busy;
    int          rises;
    int          waited;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        cyc(3);
        check_eq("reset_tx", 32'(tx), 32'h1);
        check_eq("reset_irq", 32'(irq_o), 32'h0);
        reset_ni = 1'b1;
        cyc(2);
        reg_rd(2'd0, rd); check_eq("reset_status", rd, 32'h0000_0A00);
        reg_rd(2'd2, rd); check_eq("reset_div", rd, 32'd53);
        reg_rd(2'd1, rd); check_eq("reset_data_empty", rd, 32'h0);
        reg_rd(2'd3, rd); check_eq("reserved_read", rd, 32'h0);
        check_eq("idle_tx", 32'(tx), 32'h1);

        reg_wr(2'd2, 32'h0000_1234);
        reg_rd(2'd2, rd); check_eq("div_rw", rd, 32'h1234);
        reg_wr(2'd3, 32'hFFFF_FFFF);
        reg_rd(2'd2, rd); check_eq("reserved_wr_ignored", rd, 32'h1234);
        reg_wr(2'd2, 32'h0);

        // ---------------- single frame 0xA5 at DIV=0 ----------------
        reg_wr(2'd0, 32'h1);
        reg_wr(2'd1, 32'hA5);
        reg_sel_i = 2'd0;
        waited = 0;
        while (tx !== 1'b0 && waited < 50) begin
            cyc(1);
            waited++;
        end
        check_eq("tx_start_seen", 32'(tx), 32'h0);
        samp[0] = tx;
        for (int i = 1; i < 161; i++) begin
            cyc(1);
            samp[i] = tx;
            if (i == 80) check_eq("tx_busy_midframe", 32'(salida_o[12]), 32'h1);
        end
        a5 = 8'hA5;
        for (int b = 0; b < 10; b++) begin
            logic [15:0] got16;
            logic        exp_bit;
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : a5[b-1];
            for (int k = 0; k < 16; k++) got16[k] = samp[b*16 + k];
            check_eq($sformatf("tx_a5_bit%0d", b), 32'(got16), exp_bit ? 32'hFFFF : 32'h0);
        end
        check_eq("tx_after_frame", 32'(samp[160]), 32'h1);
        reg_rd(2'd0, rd); check_eq("tx_busy_done", 32'(rd[12]), 32'h0);

        // ---------------- loopback 0x3C, 0xC3 ----------------
        loop_en = 1'b1;
        reg_wr(2'd0, 32'h7);
        reg_wr(2'd1, 32'h3C);
        reg_wr(2'd1, 32'hC3);
        reg_sel_i = 2'd0;
        waited = 0;
        while (salida_o[30:24] != 7'd2 && waited < 1000) begin
            cyc(1);
            waited++;
        end
        reg_rd(2'd0, rd); check_eq("loop_rx_count", 32'(rd[30:24]), 32'd2);
        check_eq("loop_irq", 32'(irq_o), 32'h1);
        data_pop(rd); check_eq("loop_rd0", rd, 32'h3C);
        data_pop(rd); check_eq("loop_rd1", rd, 32'hC3);
        reg_rd(2'd0, rd); check_eq("loop_rx_empty", 32'(rd[11]), 32'h1);
        check_eq("loop_irq_clear", 32'(irq_o), 32'h0);

        // ---------------- TX FIFO fill, 9th byte lost ----------------
        reg_wr(2'd0, 32'h0);
        for (int i = 0; i < 9; i++) reg_wr(2'd1, 32'h10 + 32'(i));
        reg_rd(2'd0, rd);
        check_eq("txfill_count", 32'(rd[22:16]), 32'd8);
        check_eq("txfill_full", 32'(rd[8]), 32'h1);
        reg_wr(2'd0, 32'h3);
        reg_sel_i = 2'd0;
        #1;
        prev_busy = salida_o[12];
        rises = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            if (salida_o[12] && !prev_busy) rises++;
            prev_busy = salida_o[12];
        end
        check_eq("txfill_frames", 32'(rises), 32'd8);
        reg_rd(2'd0, rd);
        check_eq("txfill_rx_count", 32'(rd[30:24]), 32'd8);
        check_eq("txfill_rx_full", 32'(rd[10]), 32'h1);
        check_eq("txfill_no_overrun", 32'(rd[13]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            data_pop(rd);
            check_eq($sformatf("txfill_rd%0d", i), rd, 32'h10 + 32'(i));
        end

        // ---------------- RX overrun ----------------
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        reg_wr(2'd0, 32'h2);
        cyc(4);
        for (int i = 0; i < 9; i++) send_rx(8'h20 + 8'(i), 1'b1);
        reg_rd(2'd0, rd);
        check_eq("ovr_rx_full", 32'(rd[10]), 32'h1);
        check_eq("ovr_flag", 32'(rd[13]), 32'h1);
        check_eq("ovr_irq", 32'(irq_o), 32'h1);
        reg_wr(2'd0, 32'h43);
        reg_rd(2'd0, rd);
        check_eq("ovr_cleared", 32'(rd[13]), 32'h0);
        check_eq("ovr_rx_count", 32'(rd[30:24]), 32'd8);
        check_eq("ovr_irq_clear", 32'(irq_o), 32'h0);
        for (int i = 0; i < 8; i++) begin
            data_pop(rd);
            check_eq($sformatf("ovr_rd%0d", i), rd, 32'h20 + 32'(i));
        end

        // ---------------- framing error and glitch ----------------
        send_rx(8'h55, 1'b0);
        reg_rd(2'd0, st);
        check_eq("ferr_flag", 32'(st[14]), 32'h1);
        check_eq("ferr_count", 32'(st[30:24]), 32'd1);
        check_eq("ferr_irq", 32'(irq_o), 32'h1);
        data_pop(rd); check_eq("ferr_byte", rd, 32'h55);
        reg_wr(2'd0, 32'h42);
        reg_rd(2'd0, st); check_eq("ferr_cleared", 32'(st[14]), 32'h0);

        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(40);
        reg_rd(2'd0, st);
        check_eq("glitch_no_byte", 32'(st[30:24]), 32'd0);
        check_eq("glitch_no_ferr", 32'(st[14]), 32'h0);
        send_rx(8'h81, 1'b1);
        reg_rd(2'd0, st); check_eq("post_glitch_count", 32'(st[30:24]), 32'd1);
        data_pop(rd); check_eq("post_glitch_byte", rd, 32'h81);

        // ---------------- reset mid-frame ----------------
        reg_wr(2'd0, 32'h1);
        reg_wr(2'd1, 32'h00);
        cyc(20);
        check_eq("midframe_tx_low", 32'(tx), 32'h0);
        #2;
        reset_ni = 1'b0;
        #1;
        check_eq("reset_async_tx", 32'(tx), 32'h1);
        cyc(2);
        reset_ni = 1'b1;
        cyc(2);
        reg_rd(2'd0, rd); check_eq("reset2_status", rd, 32'h0000_0A00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
